// File: rtl/design05_cmd_sequencer.sv
// Command sequencer: queues (a,b,c,d) operand commands in a 2-entry FIFO and
// replays each one as start -> result -> check against the downstream design.
// Latency: EN_cmd in cycle 0 gives EN_start in cycle 2 and resp_valid in cycle 5 with all readies high.
// Backpressure: RDY_cmd drops while the FIFO is full; a held response blocks the next start until resp_ack.
//
// Ports:
//   CLK, RST_N                       clock, async active-low reset
//   cmd_a/b/c/d, EN_cmd, RDY_cmd     command enqueue side
//   start_a/b, EN_start, st_ready    design start interface
//   result_c, result, res_ready      design result interface
//   check_d, EN_check, check, ch_ready  design check interface
//   resp_*, resp_ack                 response to consumer
//   done_count                       completed transactions (timeouts included), wrapping
module design05_cmd_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [8:0]       cmd_a,
  input  logic [8:0]       cmd_b,
  input  logic [8:0]       cmd_c,
  input  logic [8:0]       cmd_d,
  input  logic             EN_cmd,
  output logic             RDY_cmd,
  output logic [8:0]       start_a,
  output logic [8:0]       start_b,
  output logic             EN_start,
  input  logic             st_ready,
  output logic [8:0]       result_c,
  input  logic [8:0]       result,
  input  logic             res_ready,
  output logic [8:0]       check_d,
  output logic             EN_check,
  input  logic [8:0]       check,
  input  logic             ch_ready,
  output logic             resp_valid,
  output logic [8:0]       resp_result,
  output logic [8:0]       resp_check,
  output logic             resp_timeout,
  input  logic             resp_ack,
  output logic [CNT_W-1:0] done_count
);

  typedef struct packed {
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] c;
    logic [8:0] d;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, START, RESULT, CHECK, RESP} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state;
  cmd_t       fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] fifo_cnt;
  cmd_t       head;
  logic [8:0] work_c;
  logic [8:0] work_d;
  logic [7:0] timer;

  logic fifo_empty;
  logic enq;
  logic deq;
  logic in_start;
  logic fire_start;
  logic start_tmo;
  logic timer_hit;

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign RDY_cmd    = (fifo_cnt != 2'd2);
  assign enq        = EN_cmd && RDY_cmd;
  assign timer_hit  = (timer == TMO);
  assign in_start   = (state == START);
  assign fire_start = in_start && st_ready;
  assign start_tmo  = in_start && !st_ready && timer_hit;
  // The head leaves the FIFO whether the start fires or is abandoned.
  assign deq        = fire_start || start_tmo;

  // Design-facing outputs are driven only in their owning state.
  assign start_a    = in_start ? head.a : 9'd0;
  assign start_b    = in_start ? head.b : 9'd0;
  assign EN_start   = fire_start;
  assign result_c   = (state == RESULT) ? work_c : 9'd0;
  assign check_d    = (state == CHECK) ? work_d : 9'd0;
  assign EN_check   = (state == CHECK) && ch_ready;
  assign resp_valid = (state == RESP);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (enq) begin
        fifo_mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, c: cmd_c, d: cmd_d};
        wr_ptr           <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      timer        <= 8'd0;
      work_c       <= 9'd0;
      work_d       <= 9'd0;
      resp_result  <= 9'd0;
      resp_check   <= 9'd0;
      resp_timeout <= 1'b0;
      done_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            // New transaction: uncaptured values must read back as 0.
            state        <= START;
            timer        <= 8'd0;
            resp_result  <= 9'd0;
            resp_check   <= 9'd0;
            resp_timeout <= 1'b0;
          end
        end
        START: begin
          if (st_ready) begin
            work_c <= head.c;
            work_d <= head.d;
            timer  <= 8'd0;
            state  <= RESULT;
          end else if (timer_hit) begin
            resp_timeout <= 1'b1;
            state        <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            resp_result <= result;
            timer       <= 8'd0;
            state       <= CHECK;
          end else if (timer_hit) begin
            resp_timeout <= 1'b1;
            state        <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        CHECK: begin
          if (ch_ready) begin
            resp_check <= check;
            timer      <= 8'd0;
            state      <= RESP;
          end else if (timer_hit) begin
            resp_timeout <= 1'b1;
            state        <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          if (resp_ack) begin
            done_count <= done_count + CNT_W'(1);
            timer      <= 8'd0;
            if (!fifo_empty) begin
              state        <= START;
              resp_result  <= 9'd0;
              resp_check   <= 9'd0;
              resp_timeout <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/design05_cmd_sequencer.md
Name: design05_cmd_sequencer

Overview:
- Upstream driver stage for the mkDesign_05 start/result/check interface.
- Buffers operand commands (a, b, c, d) in a 2-entry FIFO and replays each command as one ordered transaction: fire start, then read result, then fire check.
- Waits on the design's ready lines at each step, with a per-step timeout.
- Returns the captured result and check values, plus a timeout flag, to a response consumer.

Parameters:
- TIMEOUT, 255, maximum cycles spent waiting on any single ready line before the transaction is aborted (1..255).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- cmd_a  in  9  start operand a
- cmd_b  in  9  start operand b
- cmd_c  in  9  result argument c
- cmd_d  in  9  check argument d
- EN_cmd  in  1  enqueue command; honoured only when RDY_cmd=1
- RDY_cmd  out  1  command FIFO not full
- start_a  out  9  to design start_a
- start_b  out  9  to design start_b
- EN_start  out  1  to design EN_start
- st_ready  in  1  from design st_ready
- result_c  out  9  to design result_c
- result  in  9  from design result
- res_ready  in  1  from design res_ready
- check_d  out  9  to design check_d
- EN_check  out  1  to design EN_check
- check  in  9  from design check
- ch_ready  in  1  from design ch_ready
- resp_valid  out  1  response held for consumer
- resp_result  out  9  captured result
- resp_check  out  9  captured check
- resp_timeout  out  1  transaction aborted by timeout
- resp_ack  in  1  consumer accepts response; honoured only when resp_valid=1
- done_count  out  CNT_W  completed transactions (timeouts included), wraps to 0

Behaviour:
- Reset (asynchronous, on RST_N=0):
  - FSM to IDLE; FIFO emptied, so RDY_cmd=1.
  - All other outputs 0; wait timer 0; done_count 0.
  - No EN_start/EN_check pulse in the first cycle after release.
  - Reset asserted mid-transaction abandons the transaction; no response is produced for it.
- FIFO:
  - 2 entries, in-order.
  - EN_cmd while full is ignored.
  - Enqueue and dequeue in the same cycle are legal when not full; occupancy is unchanged.
  - Head entry is dequeued on the cycle EN_start fires, or on a START timeout.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, go to START next cycle.
  - START:
    - start_a/start_b = FIFO head; EN_start = st_ready (combinational).
    - On fire: latch head c,d into working registers, clear timer, go to RESULT.
  - RESULT:
    - result_c = working c.
    - When res_ready=1: capture result into resp_result, clear timer, go to CHECK.
  - CHECK:
    - check_d = working d; EN_check = ch_ready.
    - On fire: capture check into resp_check, go to RESP.
  - RESP:
    - resp_valid=1 and all resp_* outputs held stable.
    - On resp_ack: done_count+1, then go to START if the FIFO is non-empty, else IDLE.
- Outputs outside their owning state: start_a, start_b, result_c, check_d = 0; EN_start, EN_check = 0.
- Timeout:
  - Timer increments each cycle spent in START, RESULT or CHECK while the awaited ready is 0.
  - When timer == TIMEOUT and ready is still 0: go to RESP with resp_timeout=1.
  - Values not yet captured are reported as 0. A START timeout dequeues the head entry.
  - If ready rises in the same cycle the timer reaches TIMEOUT, the handshake wins and resp_timeout=0.
- resp_timeout clears on the cycle a new transaction enters START.
- Latency with all readies high:
  - EN_cmd in cycle 0 gives IDLE in cycle 1, START/EN_start in cycle 2, RESULT in 3, CHECK/EN_check in 4, resp_valid in cycle 5.
  - Back-to-back transactions (ack in RESP, FIFO non-empty): EN_start 1 cycle after ack.
- done_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Single command a=3,b=5,c=7,d=9; all readies tied 1; design returns result=0x0AA, check=0x155 -> EN_start in cycle 2 with start_a=3/start_b=5, result_c=7 in cycle 3, EN_check in cycle 4 with check_d=9, resp_valid in cycle 5 with 0x0AA/0x155, resp_timeout=0; done_count=1 after ack.
- Enqueue 3 commands on consecutive cycles with st_ready=0 -> RDY_cmd=0 after the 2nd enqueue, 3rd command ignored; raise st_ready -> exactly 2 transactions in order.
- res_ready held 0 with TIMEOUT=4 -> resp_timeout=1 after 4 wait cycles, resp_result=0, resp_check=0, EN_check never pulses; next command proceeds normally.
- ch_ready rises exactly on the TIMEOUT cycle -> EN_check fires, resp_timeout=0, check captured.
- RST_N pulled low while in CHECK -> all outputs 0 immediately, FIFO empty, RDY_cmd=1, no resp_valid after release.
- resp_ack held 0 for 10 cycles with second command queued -> resp_* stable, no EN_start; ack -> EN_start next cycle.
